// File: rtl/hazard_ctrl.sv
// hazard_ctrl: five-stage pipeline hazard unit.
// Detects load-use hazards, applies EX redirects and freezes the pipe while
// data memory is busy. A memory access that never completes parks the block in
// TIMEOUT until reset. stall_cnt and flush_cnt are saturating event counters.
module hazard_ctrl #(
   parameter int WAIT_LIMIT = 256
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rdidx,
   input  logic [4:0]  id_r1idx,
   input  logic [4:0]  id_r2idx,
   input  logic        id_uses_r1,
   input  logic        id_uses_r2,
   input  logic        ex_redirect,
   input  logic        dmem_req,
   input  logic        dmem_ready,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_clear,
   output logic        idex_en,
   output logic        idex_clear,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic [1:0]  state,
   output logic        mem_timeout,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_TIMEOUT  = 2'd2
   } state_t;

   // wait_cnt value seen during the WAIT_LIMIT-th consecutive stall cycle
   localparam logic [8:0] LAST_WAIT = 9'(WAIT_LIMIT - 1);

   state_t     state_q, state_nxt;
   logic [8:0] wait_q, wait_nxt;
   logic       lu_hazard;
   logic       mem_stall;
   logic       stall_evt;
   logic       flush_evt;

   // Hazard terms seen by the instructions currently in ID, EX and MEM.
   // A load into x0 never creates a dependency, and an operand the ID
   // instruction does not read cannot cause a stall.
   assign lu_hazard = ex_memread && (ex_rdidx != 5'd0) &&
                      ((id_uses_r1 && (id_r1idx == ex_rdidx)) ||
                       (id_uses_r2 && (id_r2idx == ex_rdidx)));
   assign mem_stall = dmem_req && !dmem_ready;

   // State and wait counter register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; combinational blocks below use blocking (=).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_RUN;
         wait_q  <= '0;
      end else begin
         state_q <= state_nxt;
         wait_q  <= wait_nxt;
      end
   end

   // Next-state logic: track consecutive memory-stall cycles, trap on limit.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_nxt = state_q;
      wait_nxt  = wait_q;
      unique case (state_q)
         ST_RUN: begin
            if (mem_stall) begin
               state_nxt = ST_MEM_WAIT;
               wait_nxt  = 9'd1;
            end
         end
         ST_MEM_WAIT: begin
            if (!mem_stall) begin
               state_nxt = ST_RUN;
               wait_nxt  = '0;
            end else if (wait_q >= LAST_WAIT) begin
               state_nxt = ST_TIMEOUT;
            end else begin
               wait_nxt  = wait_q + 9'd1;
            end
         end
         ST_TIMEOUT: begin
            state_nxt = ST_TIMEOUT;
         end
         default: begin
            state_nxt = ST_RUN;
            wait_nxt  = '0;
         end
      endcase
   end

   // Pipeline-control outputs: zero-latency decode of state and inputs.
   // A redirect arriving during a memory stall is held off implicitly: EX is
   // frozen, so ex_redirect is still present in the first unstalled cycle.
   always_comb begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_clear = 1'b0;
      idex_en    = 1'b1;
      idex_clear = 1'b0;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      stall_evt  = 1'b0;
      flush_evt  = 1'b0;
      if (!rstn) begin
         // Hold the whole pipe and keep both front registers cleared in reset.
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         ifid_clear = 1'b1;
         idex_en    = 1'b0;
         idex_clear = 1'b1;
         exmem_en   = 1'b0;
         memwb_en   = 1'b0;
      end else if (state_q == ST_TIMEOUT) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
      end else if (mem_stall) begin
         pc_en     = 1'b0;
         ifid_en   = 1'b0;
         idex_en   = 1'b0;
         exmem_en  = 1'b0;
         memwb_en  = 1'b0;
         stall_evt = 1'b1;
      end else if (ex_redirect) begin
         ifid_clear = 1'b1;
         idex_clear = 1'b1;
         flush_evt  = 1'b1;
      end else if (lu_hazard) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_clear = 1'b1;
         stall_evt  = 1'b1;
      end
   end

   assign state       = state_q;
   assign mem_timeout = (state_q == ST_TIMEOUT);

   // Saturating stall and flush counters; frozen in TIMEOUT via the event terms.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_evt && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (flush_evt && (flush_cnt != 32'hFFFF_FFFF)) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl.
// Control outputs are compared as a packed vector
// {pc_en, ifid_en, ifid_clear, idex_en, idex_clear, exmem_en, memwb_en}.
module tb_hazard_ctrl;

   logic        clk;
   logic        rstn;
   logic        ex_memread;
   logic [4:0]  ex_rdidx;
   logic [4:0]  id_r1idx;
   logic [4:0]  id_r2idx;
   logic        id_uses_r1;
   logic        id_uses_r2;
   logic        ex_redirect;
   logic        dmem_req;
   logic        dmem_ready;
   logic        pc_en;
   logic        ifid_en;
   logic        ifid_clear;
   logic        idex_en;
   logic        idex_clear;
   logic        exmem_en;
   logic        memwb_en;
   logic [1:0]  state;
   logic        mem_timeout;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   int total = 0;
   int bad   = 0;

   localparam logic [6:0] CTL_RESET = 7'b0010100;
   localparam logic [6:0] CTL_RUN   = 7'b1101011;
   localparam logic [6:0] CTL_HOLD  = 7'b0000000;
   localparam logic [6:0] CTL_FLUSH = 7'b1111111;
   localparam logic [6:0] CTL_LU    = 7'b0001111;

   logic [6:0] ctl;
   assign ctl = {pc_en, ifid_en, ifid_clear, idex_en, idex_clear, exmem_en, memwb_en};

   hazard_ctrl #(.WAIT_LIMIT(256)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .ex_memread  (ex_memread),
      .ex_rdidx    (ex_rdidx),
      .id_r1idx    (id_r1idx),
      .id_r2idx    (id_r2idx),
      .id_uses_r1  (id_uses_r1),
      .id_uses_r2  (id_uses_r2),
      .ex_redirect (ex_redirect),
      .dmem_req    (dmem_req),
      .dmem_ready  (dmem_ready),
      .pc_en       (pc_en),
      .ifid_en     (ifid_en),
      .ifid_clear  (ifid_clear),
      .idex_en     (idex_en),
      .idex_clear  (idex_clear),
      .exmem_en    (exmem_en),
      .memwb_en    (memwb_en),
      .state       (state),
      .mem_timeout (mem_timeout),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 ns so outputs are sampled off-edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ex_memread  = 1'b0;
      ex_rdidx    = 5'd0;
      id_r1idx    = 5'd0;
      id_r2idx    = 5'd0;
      id_uses_r1  = 1'b0;
      id_uses_r2  = 1'b0;
      ex_redirect = 1'b0;
      dmem_req    = 1'b0;
      dmem_ready  = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rstn = 1'b0;
      #12;
      check("reset_ctl",   32'(ctl), 32'(CTL_RESET));
      check("reset_state", 32'(state), 32'd0);
      check("reset_tmo",   32'(mem_timeout), 32'd0);
      check("reset_stall", stall_cnt, 32'd0);
      check("reset_flush", flush_cnt, 32'd0);
      rstn = 1'b1;
      tick();
      check("run_ctl",   32'(ctl), 32'(CTL_RUN));
      check("run_state", 32'(state), 32'd0);

      // Load-use on rs1
      ex_memread = 1'b1; ex_rdidx = 5'd5; id_uses_r1 = 1'b1; id_r1idx = 5'd5;
      #1;
      check("lu_r1_ctl", 32'(ctl), 32'(CTL_LU));
      tick();
      check("lu_r1_stall", stall_cnt, 32'd1);

      // Load into x0 never stalls
      ex_rdidx = 5'd0; id_r1idx = 5'd0;
      #1;
      check("x0_ctl", 32'(ctl), 32'(CTL_RUN));
      // Matching but unused operands never stall
      ex_rdidx = 5'd7; id_uses_r1 = 1'b0; id_r1idx = 5'd7; id_uses_r2 = 1'b0; id_r2idx = 5'd7;
      #1;
      check("unused_ctl", 32'(ctl), 32'(CTL_RUN));
      tick();
      check("nohaz_stall", stall_cnt, 32'd1);

      // Load-use on rs2
      id_uses_r2 = 1'b1;
      #1;
      check("lu_r2_ctl", 32'(ctl), 32'(CTL_LU));
      tick();
      check("lu_r2_stall", stall_cnt, 32'd2);

      // Redirect beats load-use
      ex_redirect = 1'b1;
      #1;
      check("redir_lu_ctl", 32'(ctl), 32'(CTL_FLUSH));
      tick();
      check("redir_flush", flush_cnt, 32'd1);
      check("redir_stall", stall_cnt, 32'd2);

      // Memory wait for 3 cycles
      idle_inputs();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      #1;
      check("mw_ctl0", 32'(ctl), 32'(CTL_HOLD));
      tick();
      check("mw_state1", 32'(state), 32'd1);
      check("mw_ctl1", 32'(ctl), 32'(CTL_HOLD));
      tick();
      tick();
      check("mw_ctl3", 32'(ctl), 32'(CTL_HOLD));
      check("mw_stall", stall_cnt, 32'd5);
      dmem_ready = 1'b1;
      #1;
      check("mw_ready_ctl", 32'(ctl), 32'(CTL_RUN));
      tick();
      check("mw_state0", 32'(state), 32'd0);
      check("mw_stall_end", stall_cnt, 32'd5);

      // Redirect during a memory stall is deferred
      dmem_ready = 1'b0; ex_redirect = 1'b1;
      #1;
      check("defer_ctl", 32'(ctl), 32'(CTL_HOLD));
      tick();
      check("defer_flush", flush_cnt, 32'd1);
      check("defer_stall", stall_cnt, 32'd6);
      dmem_ready = 1'b1;
      #1;
      check("defer_apply_ctl", 32'(ctl), 32'(CTL_FLUSH));
      tick();
      check("defer_apply_flush", flush_cnt, 32'd2);
      check("defer_state", 32'(state), 32'd0);

      // Timeout after 256 consecutive stall cycles
      ex_redirect = 1'b0; dmem_ready = 1'b0;
      for (int i = 0; i < 255; i++) tick();
      check("tmo_pre_state", 32'(state), 32'd1);
      check("tmo_pre_flag", 32'(mem_timeout), 32'd0);
      tick();
      check("tmo_state", 32'(state), 32'd2);
      check("tmo_flag", 32'(mem_timeout), 32'd1);
      check("tmo_ctl", 32'(ctl), 32'(CTL_HOLD));
      check("tmo_stall", stall_cnt, 32'd262);
      dmem_ready = 1'b1; ex_redirect = 1'b1;
      #1;
      check("tmo_ready_ctl", 32'(ctl), 32'(CTL_HOLD));
      tick();
      check("tmo_abs_state", 32'(state), 32'd2);
      check("tmo_abs_flush", flush_cnt, 32'd2);
      check("tmo_abs_stall", stall_cnt, 32'd262);

      // Asynchronous reset out of TIMEOUT, away from any edge
      #2;
      rstn = 1'b0;
      #1;
      check("areset_state", 32'(state), 32'd0);
      check("areset_tmo", 32'(mem_timeout), 32'd0);
      check("areset_ctl", 32'(ctl), 32'(CTL_RESET));
      check("areset_stall", stall_cnt, 32'd0);
      idle_inputs();
      #1;
      rstn = 1'b1;
      tick();
      check("post_reset_state", 32'(state), 32'd0);
      check("post_reset_ctl", 32'(ctl), 32'(CTL_RUN));

      // Flush counter saturation
      force dut.flush_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.flush_cnt;
      ex_redirect = 1'b1;
      tick();
      check("sat_flush_top", flush_cnt, 32'hFFFF_FFFF);
      tick();
      check("sat_flush_hold", flush_cnt, 32'hFFFF_FFFF);
      ex_redirect = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
